// File: rtl/io_serial_port.sv
// I/O-space serial transmitter: OUT writes to PORT_DATA queue bytes in a small FIFO
// that is shifted out as 8N1 frames on tx; IN reads of PORT_STATUS return FIFO/TX state.
//
// state   | meaning
// --------+----------------------------------------------
// S_IDLE  | line high, waiting for a queued byte
// S_START | start bit (tx low) for CLK_DIV cycles
// S_DATA  | eight data bits, LSB first, CLK_DIV cycles each
// S_STOP  | stop bit (tx high) for CLK_DIV cycles
module io_serial_port #(
    parameter logic [7:0] PORT_DATA   = 8'h00,
    parameter logic [7:0] PORT_STATUS = 8'h01,
    parameter int         CLK_DIV     = 4,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr_bus,
    input  logic       mem_io,
    input  logic       c_ri,
    input  logic       c_ro,
    input  logic       mem_clk,
    inout  wire  [7:0] bus,
    output logic       tx,
    output logic       tx_busy
);

    localparam int            PW       = $clog2(FIFO_DEPTH);
    localparam int            CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    div, div_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift_reg, shift_n;
    logic          tx_n, busy_n, pop;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          mem_clk_q;

    logic          mc_rise, wr_hit, rd_hit, full, empty;
    logic          push_req, push_ok, ovf_set, ovf_clr;
    logic [7:0]    status;

    assign mc_rise  = mem_clk & ~mem_clk_q;
    assign wr_hit   = mem_io & c_ri & (addr_bus == PORT_DATA);
    assign rd_hit   = mem_io & c_ro & (addr_bus == PORT_STATUS);
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);

    // A pop on the same edge frees a slot, so a push into a full FIFO is still taken.
    assign push_req = wr_hit & mc_rise;
    assign push_ok  = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;
    assign ovf_clr  = rd_hit & mc_rise;

    assign status   = {4'b0000, overflow, tx_busy, full, empty};
    assign bus      = rd_hit ? status : 8'hzz;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_clk_q <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            mem_clk_q <= mem_clk;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        state_n   = state;
        div_n     = div;
        bit_idx_n = bit_idx;
        shift_n   = shift_reg;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_mem[rd_ptr];
                    div_n   = 8'd0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (div == DIV_LAST) begin
                    div_n     = 8'd0;
                    bit_idx_n = 3'd0;
                    state_n   = S_DATA;
                end else begin
                    div_n = div + 8'd1;
                end
            end
            S_DATA: begin
                if (div == DIV_LAST) begin
                    div_n   = 8'd0;
                    shift_n = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    div_n = div + 8'd1;
                end
            end
            S_STOP: begin
                if (div == DIV_LAST) begin
                    div_n   = 8'd0;
                    state_n = S_IDLE;
                end else begin
                    div_n = div + 8'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // tx/tx_busy are registered from the next-state view so the line changes on the entry edge.
        busy_n = (state_n != S_IDLE);
        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            div       <= 8'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            state     <= state_n;
            div       <= div_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_n;
            tx        <= tx_n;
            tx_busy   <= busy_n;
        end
    end

endmodule

// File: tb/tb_io_serial_port.sv
// Bench for io_serial_port: vector table, directed corner sequences and random bus
// traffic checked against a timer/queue model of the transmitter and a tx frame decoder.
module tb_io_serial_port;

    localparam int         C     = 4;
    localparam int         DEPTH = 4;
    localparam logic [7:0] PD    = 8'h00;
    localparam logic [7:0] PS    = 8'h01;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] addr_bus = 8'h00;
    logic       mem_io = 1'b0;
    logic       c_ri = 1'b0;
    logic       c_ro = 1'b0;
    logic       mem_clk = 1'b0;
    logic       drv_en = 1'b0;
    logic [7:0] drv_val = 8'h00;
    wire  [7:0] bus;
    logic       tx, tx_busy;

    int checks = 0;
    int errors = 0;

    assign bus = drv_en ? drv_val : 8'hzz;
    pullup (bus);

    io_serial_port #(.PORT_DATA(PD), .PORT_STATUS(PS), .CLK_DIV(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .addr_bus(addr_bus), .mem_io(mem_io), .c_ri(c_ri),
        .c_ro(c_ro), .mem_clk(mem_clk), .bus(bus), .tx(tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: queued bytes, a frame timer counting down from 10*C, sticky overflow.
    logic [7:0] q [$];
    logic [7:0] sent_q [$];
    logic [7:0] rx_q [$];
    int         timer = 0;
    logic [7:0] cur = 8'h00;
    logic       ovf_m = 1'b0;
    logic       mc_prev_m = 1'b0;

    function automatic logic [7:0] model_status();
        return {4'b0000, ovf_m, (timer > 0), (q.size() == DEPTH), (q.size() == 0)};
    endfunction

    function automatic logic exp_tx();
        int slot;
        if (timer == 0) return 1'b1;
        slot = (10 * C - timer) / C;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return cur[slot-1];
    endfunction

    always @(posedge clk) begin : model
        bit push_req, rdclr, pop, full, set;
        if (reset) begin
            q.delete();
            sent_q.delete();
            timer     = 0;
            ovf_m     = 1'b0;
            mc_prev_m = 1'b0;
        end else begin
            push_req = mem_io && c_ri && (addr_bus == PD) && mem_clk && !mc_prev_m;
            rdclr    = mem_io && c_ro && (addr_bus == PS) && mem_clk && !mc_prev_m;
            pop      = (timer == 0) && (q.size() > 0);
            full     = (q.size() == DEPTH);
            set      = push_req && full && !pop;
            if (timer > 0) timer--;
            if (pop) begin
                cur = q.pop_front();
                sent_q.push_back(cur);
                timer = 10 * C;
            end
            if (push_req && !set) q.push_back(drv_val);
            if (set) ovf_m = 1'b1;
            else if (rdclr) ovf_m = 1'b0;
            mc_prev_m = mem_clk;
        end
        #1;
        chk("cyc_tx", int'(tx), int'(exp_tx()));
        chk("cyc_busy", int'(tx_busy), int'(timer > 0));
    end

    // Frame decoder: samples each bit in the middle of its C-cycle slot.
    logic       mon_on = 1'b0;
    logic       prev_tx = 1'b1;
    int         mk = 0;
    logic [7:0] mb = 8'h00;

    always @(posedge clk) begin : monitor
        #1;
        if (reset) begin
            mon_on  = 1'b0;
            prev_tx = 1'b1;
        end else if (!mon_on) begin
            if (prev_tx && !tx) begin
                mon_on = 1'b1;
                mk     = 0;
            end
            prev_tx = tx;
        end else begin
            mk++;
            if (mk % C == C / 2) begin
                if (mk / C == 0) chk("mon_start", int'(tx), 0);
                else if (mk / C <= 8) mb[mk/C-1] = tx;
                else begin
                    chk("mon_stop", int'(tx), 1);
                    rx_q.push_back(mb);
                    mon_on = 1'b0;
                end
            end
            prev_tx = tx;
        end
    end

    task automatic io_write(input logic [7:0] a, input logic mio, input logic [7:0] d, input int hold);
        @(negedge clk);
        addr_bus = a; mem_io = mio; c_ri = 1'b1; drv_en = 1'b1; drv_val = d; mem_clk = 1'b1;
        repeat (hold) @(negedge clk);
        mem_clk = 1'b0; c_ri = 1'b0; drv_en = 1'b0; mem_io = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] a, input logic mio, output logic [7:0] val,
                           output logic [7:0] exp_m);
        @(negedge clk);
        addr_bus = a; mem_io = mio; c_ro = 1'b1; mem_clk = 1'b1;
        #1;
        val   = bus;
        exp_m = (mio && a == PS) ? model_status() : 8'hFF;
        @(negedge clk);
        mem_clk = 1'b0; c_ro = 1'b0; mem_io = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk);
            #2;
            if (timer == 0 && q.size() == 0 && !mon_on) done = 1'b1;
        end
        chk({name, "_idle"}, int'(done), 1);
    endtask

    logic [7:0] exp_list [8];

    task automatic check_frames(input string name, input int n, input bit use_list);
        chk({name, "_nframes_vs_model"}, rx_q.size(), sent_q.size());
        if (use_list) begin
            chk({name, "_nframes"}, rx_q.size(), n);
            for (int i = 0; i < n && i < rx_q.size(); i++)
                chk($sformatf("%s_byte%0d", name, i), rx_q[i], exp_list[i]);
        end
        for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
            chk($sformatf("%s_model_byte%0d", name, i), rx_q[i], sent_q[i]);
        rx_q.delete();
        sent_q.delete();
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic       mio;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vt [8];

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : main
        logic [7:0] val, em;
        logic [7:0] wave [48];
        int         busy_cnt;
        logic [7:0] byte_rx;
        bit         found;

        vt[0] = '{1'b0, PS,    1'b1, 8'h00, 8'h01};
        vt[1] = '{1'b0, 8'h02, 1'b1, 8'h00, 8'hFF};
        vt[2] = '{1'b0, PS,    1'b0, 8'h00, 8'hFF};
        vt[3] = '{1'b0, PD,    1'b1, 8'h00, 8'hFF};
        vt[4] = '{1'b1, 8'h05, 1'b1, 8'h55, 8'h01};
        vt[5] = '{1'b1, PS,    1'b1, 8'hAA, 8'h01};
        vt[6] = '{1'b1, PD,    1'b0, 8'h77, 8'h01};
        vt[7] = '{1'b0, 8'h81, 1'b1, 8'h00, 8'hFF};

        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(tx_busy), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (vt[i].wr) begin
                io_write(vt[i].addr, vt[i].mio, vt[i].data, 1);
                repeat (2) @(negedge clk);
                io_read(PS, 1'b1, val, em);
            end else begin
                io_read(vt[i].addr, vt[i].mio, val, em);
            end
            chk($sformatf("vec%0d", i), val, vt[i].exp);
        end
        repeat (50) @(negedge clk);
        check_frames("vec_noframe", 0, 1'b1);

        // Single A5 frame: fall one edge after the push edge, 40 busy cycles.
        @(negedge clk);
        addr_bus = PD; mem_io = 1'b1; c_ri = 1'b1; drv_en = 1'b1; drv_val = 8'hA5; mem_clk = 1'b1;
        @(posedge clk);
        #1;
        chk("a5_push_edge_tx", int'(tx), 1);
        chk("a5_push_edge_busy", int'(tx_busy), 0);
        @(negedge clk);
        mem_clk = 1'b0; c_ri = 1'b0; drv_en = 1'b0; mem_io = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            wave[k] = tx;
            busy_cnt += int'(tx_busy);
        end
        chk("a5_fall", int'(wave[0]), 0);
        for (int j = 1; j <= 8; j++) byte_rx[j-1] = wave[j*C+1];
        chk("a5_bits", byte_rx, 8'hA5);
        chk("a5_stop", int'(wave[9*C+1]), 1);
        chk("a5_busy_cycles", busy_cnt, 10 * C);
        wait_idle("a5");
        exp_list = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_frames("a5", 1, 1'b1);

        // Long mem_clk pulse: one push only.
        io_write(PD, 1'b1, 8'h3C, 5);
        wait_idle("hold5");
        exp_list = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_frames("hold5", 1, 1'b1);

        // Five pushes during a frame, then an overflowing push and two status reads.
        for (int i = 1; i <= 5; i++) io_write(PD, 1'b1, 8'(i), 1);
        io_read(PS, 1'b1, val, em);
        chk("burst_status_full", val, 8'h06);
        io_write(PD, 1'b1, 8'h06, 1);
        io_read(PS, 1'b1, val, em);
        chk("ovf_status_read1", val, 8'h0E);
        io_read(PS, 1'b1, val, em);
        chk("ovf_status_read2", val, 8'h06);
        wait_idle("burst");
        exp_list = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00};
        check_frames("burst", 5, 1'b1);

        // Push into a full FIFO on the very edge the idle state pops.
        for (int i = 0; i < 5; i++) io_write(PD, 1'b1, 8'h31 + 8'(i), 1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #2;
            if (timer == 0) found = 1'b1;
        end
        chk("popedge_align", int'(found), 1);
        io_write(PD, 1'b1, 8'h36, 1);
        io_read(PS, 1'b1, val, em);
        chk("popedge_status", val, 8'h06);
        wait_idle("popedge");
        exp_list = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h00, 8'h00};
        check_frames("popedge", 6, 1'b1);

        // Reset in the middle of an FF frame with two bytes queued.
        io_write(PD, 1'b1, 8'hFF, 1);
        io_write(PD, 1'b1, 8'h11, 1);
        io_write(PD, 1'b1, 8'h22, 1);
        repeat (8) @(negedge clk);
        chk("rst_mid_busy_before", int'(tx_busy), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_tx", int'(tx), 1);
        chk("rst_mid_busy", int'(tx_busy), 0);
        @(negedge clk);
        reset = 1'b0;
        io_read(PS, 1'b1, val, em);
        chk("rst_mid_status", val, 8'h01);
        repeat (200) @(negedge clk);
        rx_q.delete();
        wait_idle("rst_mid");
        check_frames("rst_mid", 0, 1'b1);

        // Random bus traffic against the model.
        for (int n = 0; n < 300; n++) begin
            logic [7:0] a;
            logic       mio;
            int         r;
            r   = $urandom_range(0, 3);
            mio = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 4))
                0, 1:    a = (r < 2) ? PD : PS;
                2:       a = PS;
                3:       a = 8'h05;
                default: a = 8'($urandom);
            endcase
            if (r < 2) begin
                io_write(a, mio, 8'($urandom), $urandom_range(1, 3));
            end else if (r == 2) begin
                io_read(a, mio, val, em);
                chk($sformatf("rand_read%0d", n), val, em);
            end else begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
        end
        wait_idle("rand");
        check_frames("rand", 0, 1'b0);
        io_read(PS, 1'b1, val, em);
        chk("rand_final_status", val, em);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_serial_port.md
Name: io_serial_port

Overview:
- I/O-space responder on the CPU's shared 8-bit bus, at the far end of the CPU's OUT/IN cycles.
- Decodes I/O cycles (mem_io high) addressed to its two ports.
- Buffers OUT bytes in a small FIFO and serialises them onto a TX line as 8N1 frames.
- Answers IN cycles on the status port with FIFO and transmitter state.

Parameters:
- PORT_DATA, 8'h00, I/O address of the transmit data port (write-only).
- PORT_STATUS, 8'h01, I/O address of the status port (read-only).
- CLK_DIV, 4, clk cycles per serial bit; legal range 1..255.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr_bus  input  8  I/O address driven from the CPU's MAR.
- mem_io  input  1  high = I/O cycle, low = memory cycle (this block ignores memory cycles).
- c_ri  input  1  write strobe; in I/O space it marks an OUT write.
- c_ro  input  1  read strobe; in I/O space it marks an IN read.
- mem_clk  input  1  CPU memory phase clock; sampled as a data signal, never used as a clock.
- bus  inout  8  shared data bus.
- tx  output  1  serial output; idles high.
- tx_busy  output  1  high while a frame is being shifted out.

Behaviour:
- Reset (async): tx=1, tx_busy=0, FSM=IDLE, FIFO empty (rd_ptr=wr_ptr=count=0), overflow=0, mem_clk_q=0, bus released to Z. Reset mid-frame aborts the frame immediately: tx returns high and the FIFO contents are discarded.
- Strobe qualification:
  - mem_clk_q <= mem_clk on every clk edge.
  - mc_rise = mem_clk & ~mem_clk_q.
  - wr_hit = mem_io & c_ri & (addr_bus==PORT_DATA).
  - rd_hit = mem_io & c_ro & (addr_bus==PORT_STATUS).
- Push:
  - On a clk edge where wr_hit & mc_rise, bus is written at wr_ptr.
  - Exactly one push per mem_clk pulse, regardless of how long the pulse lasts.
  - Push when full (and no pop that cycle): byte dropped, overflow set to 1 (sticky).
- Status read:
  - bus = {4'b0, overflow, tx_busy, full, empty} combinationally while rd_hit; otherwise bus=Z.
  - The driver also releases bus whenever mem_io=0.
  - overflow clears on the clk edge where rd_hit & mc_rise, unless a new overflow occurs on that same edge; setting wins.
- Reads of PORT_DATA and writes to PORT_STATUS are ignored: bus stays Z and no state changes.
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. count is 0..FIFO_DEPTH; full = count==FIFO_DEPTH, empty = count==0.
- Simultaneous push and pop: both take effect and count is unchanged. This also applies when full: the push is accepted and no overflow is flagged.
- FSM (bit counter 3 bits, divider counter 8 bits):
  - IDLE: tx=1, tx_busy=0. If FIFO is non-empty, pop the head into shift_reg, div=0, go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift_reg[0] for CLK_DIV cycles per bit, then shift right. After bit 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles, then go to IDLE.
  - tx_busy=1 in START, DATA and STOP.
- Frame timing:
  - Frame length is exactly 10*CLK_DIV cycles from the falling edge of tx to the end of STOP, LSB first.
  - Back-to-back frames have exactly one IDLE cycle between them.
- Latency: given the push edge E, the pop and START entry occur at E+1, and tx falls on edge E+1.
- tx is driven from a register, so it is glitch-free.

Test Plan:
- Reset, then OUT 8'hA5 to port 8'h00 with CLK_DIV=4 → tx falls 1 edge after the push edge, then data bits 1,0,1,0,0,1,0,1 at 4 clk each, stop high; tx_busy high for exactly 40 cycles.
- Hold mem_clk high for 5 clk with wr_hit active → exactly one byte pushed (count=1), single frame transmitted.
- Push 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 rapidly while the first frame is in flight (depth 4) → all five transmitted in order, count never exceeds 4, overflow=0. Then repeat while the FIFO is full with no pop pending → byte dropped and a status read returns bit3=1; a second read returns bit3=0.
- IN from port 8'h01 while idle and empty → bus=8'h01. IN from port 8'h02 or with mem_io=0 → bus=Z. OUT to port 8'h05 → no push.
- Assert reset mid-DATA of an 8'hFF frame with 2 bytes queued → tx=1, tx_busy=0 immediately; status read afterwards returns 8'h01 and no further frames are sent.
- Write with FIFO full on the exact edge that IDLE pops → push accepted, count stays 4, overflow=0.
